demux_rr_sched: RTL and testbench
=================================

// Module: demux_rr_sched
// PURPOSE
//  Sequencer for a 1:N demultiplexer. Accepts one input stream (valid/ready), buffers one beat and steers it
//  to one of N_OUT sinks. The select is held stable until the beat is taken. Round-robin rotation with a
//  programmable burst length. Sits between a single producer and N consumers; drives the 1:N demux datapath.
// PARAMETERS
//  N_OUT      2   number of output sinks (>=2)
//  DATA_W     8   payload width
//  BURST_LEN  1   beats sent to one sink before rotating to the next (>=1)
// PORTS
//  clk       in   1                   single clock; all state updates on rising edge
//  rst       in   1                   synchronous, active-high reset
//  s_valid   in   1                   input beat present
//  s_ready   out  1                   block can accept a beat this cycle
//  s_data    in   DATA_W              input payload
//  s_dest    in   $clog2(N_OUT)       destination index; used only with DEMUX_DEST_ROUTE_EN
//  m_valid   out  N_OUT               one-hot; bit k = beat offered to sink k
//  m_ready   in   N_OUT               per-sink ready
//  m_data    out  DATA_W              shared payload bus to all sinks
//  cur_sel   out  $clog2(N_OUT)       sink currently selected by the scheduler
//  err_drop  out  1                   1-cycle pulse: beat discarded (bad dest)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=EMPTY, m_valid=0, m_data=0, cur_sel=0, burst_cnt=0, err_drop=0. rst wins over all.
//  FSM: EMPTY (no held beat), FULL (holding beat for sink hold_sel).
//  s_ready = (state==EMPTY) | m_ready[hold_sel] when FULL. Combinational; no dependency on s_valid.
//  Accept = s_valid & s_ready. Accepted beat -> registered into m_data, hold_sel, FULL. Latency is 1 clock
//    from accept to m_valid.
//  m_valid = (state==FULL) ? (1<<hold_sel) : 0. Only one bit is ever set.
//  Deliver = FULL & m_ready[hold_sel]. m_ready of other sinks is ignored.
//  Deliver only -> EMPTY. Deliver + accept in the same cycle -> stays FULL with the new beat (no bubble,
//    full throughput).
//  FULL & !m_ready[hold_sel]: m_data, hold_sel and m_valid are held bit-stable (no retraction).
//  Rotation: a beat takes hold_sel=cur_sel at accept. On each accept burst_cnt++. When burst_cnt reaches
//    BURST_LEN-1 and a beat is accepted: burst_cnt=0 and cur_sel=(cur_sel+1) mod N_OUT, wrapping N_OUT-1 -> 0.
//  No skipping: a stalled sink blocks the stream (head-of-line), by design.
//  s_valid low: no state change. s_dest is ignored without the macro.
// CONFIGURATION
//  DEMUX_DEST_ROUTE_EN defined: hold_sel = s_dest at accept. cur_sel mirrors the last accepted s_dest.
//    burst_cnt and rotation logic are not built.
//  If s_dest >= N_OUT: the beat is accepted (s_ready honoured), not stored, err_drop pulses 1 cycle.
//    State is unchanged, except a simultaneous deliver still empties the buffer.
//  Undefined (default): round-robin/burst as above. s_dest is unused and err_drop is tied 0.
// STRUCTURE
//  Package demux_sched_pkg: state_e enum {EMPTY, FULL}; function sel_w(n)=$clog2(n), min 1.
//  Sub-module demux_1_n (combinational): in, sel -> one-hot N_OUT outputs. Instantiated here to form m_valid
//    from the FULL flag and hold_sel.
//  This module holds the FSM, data register, select register and burst counter.
// TESTING
//  1 Reset: rst=1 for 2 clks with s_valid=1 -> m_valid=0, cur_sel=0, s_ready=1 after release.
//  2 RR, N_OUT=2, BURST_LEN=1, all m_ready=1, beats 0xA1,0xA2,0xA3 back-to-back:
//    sink0 gets A1, sink1 gets A2, sink0 gets A3; one beat per clk.
//  3 Backpressure: m_ready[0]=0 for 4 clks with beat 0x55 held -> m_valid=01 and m_data=0x55 stable,
//    s_ready=0; m_ready[0]=1 -> delivered, next beat goes to sink1.
//  4 Burst: N_OUT=4, BURST_LEN=3, 7 beats -> sinks 0,0,0,1,1,1,2; cur_sel wraps 3->0 after 12 beats.
//  5 Mid-op reset: rst while FULL with m_ready=0 -> next clk m_valid=0, cur_sel=0; no beat leaks.
//  6 DEMUX_DEST_ROUTE_EN, N_OUT=3: dest 2,0,3 -> sink2, sink0; dest=3 -> err_drop one cycle, no m_valid.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the round-robin demux sequencer.
package demux_sched_pkg;

  typedef enum logic [0:0] {EMPTY, FULL} state_e;

  // Select width for n sinks, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_1_n.sv
// Combinational 1:N decoder: drives out_o[sel_i] with in_i, all other outputs low.
module demux_1_n
  import demux_sched_pkg::*;
#(
  parameter int unsigned N_OUT = 2,
  localparam int unsigned SelW = sel_w(N_OUT)
) (
  input  logic            in_i,
  input  logic [SelW-1:0] sel_i,
  output logic [N_OUT-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      out_o[k] = in_i & (sel_i == SelW'(k));
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// One-beat buffered 1:N demux sequencer with round-robin/burst rotation.
// Define DEMUX_DEST_ROUTE_EN to steer by s_dest instead of rotating.
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int unsigned N_OUT     = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 1,
  localparam int unsigned SelW = sel_w(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SelW-1:0]   s_dest,
  output logic [N_OUT-1:0]  m_valid,
  input  logic [N_OUT-1:0]  m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [SelW-1:0]   cur_sel,
  output logic              err_drop
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SelW-1:0]   hold_q, hold_d;
  logic [SelW-1:0]   cur_q, cur_d;
  logic              deliver, accept;

`ifdef DEMUX_DEST_ROUTE_EN
  localparam logic [SelW:0] NOutW = (SelW + 1)'(N_OUT);

  logic err_q, err_d;
  logic dest_ok;

  assign dest_ok  = ({1'b0, s_dest} < NOutW);
  assign err_drop = err_q;
`else
  localparam int unsigned   BurstW    = sel_w(BURST_LEN);
  localparam logic [BurstW-1:0] LastBurst = BurstW'(BURST_LEN - 1);
  localparam logic [SelW-1:0]   LastSel   = SelW'(N_OUT - 1);

  logic [BurstW-1:0] burst_q, burst_d;
  logic              unused_dest;

  assign unused_dest = ^s_dest;
  assign err_drop    = 1'b0;
`endif

  // Only the selected sink's ready matters; other sinks are ignored.
  assign deliver = (state_q == FULL) & m_ready[hold_q];
  assign s_ready = (state_q == EMPTY) | deliver;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    hold_d  = hold_q;
    cur_d   = cur_q;
`ifdef DEMUX_DEST_ROUTE_EN
    err_d   = 1'b0;
`else
    burst_d = burst_q;
`endif

    if (deliver) begin
      state_d = EMPTY;
    end

    if (accept) begin
`ifdef DEMUX_DEST_ROUTE_EN
      if (dest_ok) begin
        state_d = FULL;
        data_d  = s_data;
        hold_d  = s_dest;
        cur_d   = s_dest;
      end else begin
        // Bad destination: swallow the beat, leave the buffer as is.
        err_d = 1'b1;
      end
`else
      state_d = FULL;
      data_d  = s_data;
      hold_d  = cur_q;
      if (burst_q == LastBurst) begin
        burst_d = '0;
        cur_d   = (cur_q == LastSel) ? '0 : cur_q + SelW'(1);
      end else begin
        burst_d = burst_q + BurstW'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      hold_q  <= '0;
      cur_q   <= '0;
`ifdef DEMUX_DEST_ROUTE_EN
      err_q   <= 1'b0;
`else
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      cur_q   <= cur_d;
`ifdef DEMUX_DEST_ROUTE_EN
      err_q   <= err_d;
`else
      burst_q <= burst_d;
`endif
    end
  end

  demux_1_n #(
    .N_OUT(N_OUT)
  ) u_demux (
    .in_i (state_q == FULL),
    .sel_i(hold_q),
    .out_o(m_valid)
  );

  assign m_data  = data_q;
  assign cur_sel = cur_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched; inputs driven and outputs sampled on the falling edge.
module tb_demux_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

`ifdef DEMUX_DEST_ROUTE_EN
  logic       r_s_valid = 1'b1;
  logic       r_s_ready;
  logic [7:0] r_s_data = 8'h00;
  logic [1:0] r_s_dest = 2'd0;
  logic [2:0] r_m_valid;
  logic [2:0] r_m_ready = 3'b111;
  logic [7:0] r_m_data;
  logic [1:0] r_cur_sel;
  logic       r_err_drop;

  demux_rr_sched #(.N_OUT(3), .DATA_W(8), .BURST_LEN(1)) u_dut_r (
    .clk(clk), .rst(rst), .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data),
    .s_dest(r_s_dest), .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data),
    .cur_sel(r_cur_sel), .err_drop(r_err_drop)
  );

  initial begin
    repeat (2) @(negedge clk);
    check_eq("r_rst_mvalid", 32'(r_m_valid), 32'h0);
    check_eq("r_rst_cursel", 32'(r_cur_sel), 32'h0);
    check_eq("r_rst_err", 32'(r_err_drop), 32'h0);
    rst = 1'b0; r_s_valid = 1'b1; r_s_dest = 2'd2; r_s_data = 8'hC2;
    @(negedge clk);
    check_eq("r_d2_mvalid", 32'(r_m_valid), 32'h4);
    check_eq("r_d2_data", 32'(r_m_data), 32'hC2);
    check_eq("r_d2_cursel", 32'(r_cur_sel), 32'h2);
    r_s_dest = 2'd0; r_s_data = 8'hC0;
    @(negedge clk);
    check_eq("r_d0_mvalid", 32'(r_m_valid), 32'h1);
    check_eq("r_d0_data", 32'(r_m_data), 32'hC0);
    check_eq("r_d0_cursel", 32'(r_cur_sel), 32'h0);
    r_s_dest = 2'd3; r_s_data = 8'hC3;
    @(negedge clk);
    check_eq("r_d3_err", 32'(r_err_drop), 32'h1);
    check_eq("r_d3_mvalid", 32'(r_m_valid), 32'h0);
    check_eq("r_d3_cursel", 32'(r_cur_sel), 32'h0);
    r_s_valid = 1'b0;
    @(negedge clk);
    check_eq("r_err_pulse", 32'(r_err_drop), 32'h0);
    check_eq("r_idle_mvalid", 32'(r_m_valid), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
`else
  // Instance A: two sinks, burst of one.
  logic       a_s_valid = 1'b1;
  logic       a_s_ready;
  logic [7:0] a_s_data = 8'h77;
  logic [0:0] a_s_dest = 1'b0;
  logic [1:0] a_m_valid;
  logic [1:0] a_m_ready = 2'b11;
  logic [7:0] a_m_data;
  logic [0:0] a_cur_sel;
  logic       a_err_drop;

  // Instance B: four sinks, burst of three.
  logic       b_s_valid = 1'b0;
  logic       b_s_ready;
  logic [7:0] b_s_data = 8'h00;
  logic [1:0] b_s_dest = 2'd0;
  logic [3:0] b_m_valid;
  logic [3:0] b_m_ready = 4'b1111;
  logic [7:0] b_m_data;
  logic [1:0] b_cur_sel;
  logic       b_err_drop;

  demux_rr_sched #(.N_OUT(2), .DATA_W(8), .BURST_LEN(1)) u_dut_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_dest(a_s_dest), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
    .cur_sel(a_cur_sel), .err_drop(a_err_drop)
  );

  demux_rr_sched #(.N_OUT(4), .DATA_W(8), .BURST_LEN(3)) u_dut_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_dest(b_s_dest), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .cur_sel(b_cur_sel), .err_drop(b_err_drop)
  );

  logic [3:0] b_exp_mv [12] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2,
                                4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8};

  initial begin
    // Reset held two clocks with s_valid high.
    repeat (2) @(negedge clk);
    check_eq("rst_mvalid", 32'(a_m_valid), 32'h0);
    check_eq("rst_cursel", 32'(a_cur_sel), 32'h0);
    check_eq("rst_mdata", 32'(a_m_data), 32'h0);
    rst = 1'b0; a_s_valid = 1'b0;
    check_eq("rst_sready", 32'(a_s_ready), 32'h1);
    check_eq("rst_err", 32'(a_err_drop), 32'h0);

    // Round-robin, back-to-back.
    a_s_valid = 1'b1; a_s_data = 8'hA1;
    @(negedge clk);
    check_eq("rr_a1_mvalid", 32'(a_m_valid), 32'h1);
    check_eq("rr_a1_data", 32'(a_m_data), 32'hA1);
    check_eq("rr_a1_sready", 32'(a_s_ready), 32'h1);
    a_s_data = 8'hA2;
    @(negedge clk);
    check_eq("rr_a2_mvalid", 32'(a_m_valid), 32'h2);
    check_eq("rr_a2_data", 32'(a_m_data), 32'hA2);
    a_s_data = 8'hA3;
    @(negedge clk);
    check_eq("rr_a3_mvalid", 32'(a_m_valid), 32'h1);
    check_eq("rr_a3_data", 32'(a_m_data), 32'hA3);
    a_s_valid = 1'b0;
    @(negedge clk);
    check_eq("rr_drain_mvalid", 32'(a_m_valid), 32'h0);
    check_eq("rr_drain_cursel", 32'(a_cur_sel), 32'h1);

    // Backpressure: sink 0 stalls on 0x55 while sink 1 is ready.
    a_s_valid = 1'b1; a_s_data = 8'h10;
    @(negedge clk);
    check_eq("bp_pre_mvalid", 32'(a_m_valid), 32'h2);
    a_s_data = 8'h55; a_m_ready = 2'b10;
    @(negedge clk);
    a_s_data = 8'h66;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_hold_mvalid", 32'(a_m_valid), 32'h1);
      check_eq("bp_hold_data", 32'(a_m_data), 32'h55);
      check_eq("bp_hold_sready", 32'(a_s_ready), 32'h0);
      @(negedge clk);
    end
    a_m_ready = 2'b01;
    @(negedge clk);
    check_eq("bp_next_mvalid", 32'(a_m_valid), 32'h2);
    check_eq("bp_next_data", 32'(a_m_data), 32'h66);
    a_s_valid = 1'b0; a_m_ready = 2'b11;
    @(negedge clk);
    check_eq("bp_drain_mvalid", 32'(a_m_valid), 32'h0);

    // Reset while holding a stalled beat.
    a_s_valid = 1'b1; a_s_data = 8'h99; a_m_ready = 2'b00;
    @(negedge clk);
    check_eq("mr_full_mvalid", 32'(a_m_valid), 32'h1);
    check_eq("mr_full_cursel", 32'(a_cur_sel), 32'h1);
    rst = 1'b1; a_s_valid = 1'b0;
    @(negedge clk);
    check_eq("mr_rst_mvalid", 32'(a_m_valid), 32'h0);
    check_eq("mr_rst_cursel", 32'(a_cur_sel), 32'h0);
    check_eq("mr_rst_mdata", 32'(a_m_data), 32'h0);
    rst = 1'b0; a_m_ready = 2'b11;
    @(negedge clk);
    check_eq("mr_noleak_mvalid", 32'(a_m_valid), 32'h0);

    // Burst rotation on the four-sink instance.
    b_s_valid = 1'b1; b_s_data = 8'hB0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq($sformatf("burst%0d_mvalid", k), 32'(b_m_valid), 32'(b_exp_mv[k]));
      check_eq($sformatf("burst%0d_data", k), 32'(b_m_data), 32'(8'hB0 + k));
      if (k == 8) check_eq("burst_cursel_3", 32'(b_cur_sel), 32'h3);
      b_s_data = 8'(8'hB1 + k);
      if (k == 11) b_s_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("burst_wrap_cursel", 32'(b_cur_sel), 32'h0);
    check_eq("burst_drain_mvalid", 32'(b_m_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
`endif

endmodule
